// File: rtl/inst_boot_loader_if.sv
// Instruction stream handshake between a word source and the boot loader.
interface inst_boot_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/inst_boot_loader.sv
// Copies a program from a valid/ready stream into instruction SRAM,
// then holds the CPU in reset for a few cycles before releasing it.
module inst_boot_loader #(
    parameter int ADDR_BASE  = 1,
    parameter int MAX_WORDS  = 1024,
    parameter int RESET_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         prog_len,
    inst_boot_loader_if.slave   src,
    output logic                inst_sram_wen,
    output logic [63:0]         inst_sram_waddr,
    output logic [31:0]         inst_sram_wdata,
    output logic                inst_sram_en_toif,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        ERR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] hold_cnt;
    logic [63:0] addr;
    logic        hs;
    logic        last;
    logic        can_start;
    logic        len_ok;
    logic        load_go;

    assign hs        = (state == LOAD) && src.s_valid;
    assign last      = hs && ((cnt + 16'd1) == len);
    assign can_start = (state == IDLE) || (state == RUN) || (state == ERR);
    assign len_ok    = (prog_len != 16'd0)
                    && ({16'd0, prog_len} <= 32'(MAX_WORDS));
    assign load_go   = can_start && start && len_ok;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        src.s_ready       = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        inst_sram_en_toif = 1'b0;
        err               = 1'b0;
        cpu_reset         = 1'b1;
        if (can_start && start)
            state_nx = len_ok ? LOAD : ERR;
        unique case (state)
            IDLE: ;
            LOAD: begin
                src.s_ready = 1'b1;
                busy        = 1'b1;
                if (last) state_nx = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (hold_cnt == 16'(RESET_HOLD - 1)) state_nx = RUN;
            end
            RUN: begin
                done              = 1'b1;
                inst_sram_en_toif = 1'b1;
                cpu_reset         = 1'b0;
            end
            ERR: err = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len             <= '0;
            cnt             <= '0;
            hold_cnt        <= '0;
            addr            <= '0;
            inst_sram_wen   <= 1'b0;
            inst_sram_waddr <= '0;
            inst_sram_wdata <= '0;
        end else begin
            inst_sram_wen <= 1'b0;
            if (load_go) begin
                len  <= prog_len;
                cnt  <= '0;
                addr <= 64'(ADDR_BASE);
            end
            if (hs) begin
                inst_sram_wen   <= 1'b1;
                inst_sram_waddr <= addr;
                inst_sram_wdata <= src.s_data;
                addr            <= addr + 64'd1;
                cnt             <= cnt + 16'd1;
            end
            // hold_cnt starts at zero on the first HOLD cycle
            if (state == HOLD) hold_cnt <= hold_cnt + 16'd1;
            else               hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Directed bench for inst_boot_loader: load, stall, errors,
// reset mid-load, reload from RUN and ignored starts.
module tb_inst_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] prog_len;
    logic        wen;
    logic [63:0] waddr;
    logic [31:0] wdata;
    logic        en_toif;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;
    int          checks = 0;
    int          failures = 0;

    inst_boot_loader_if sif ();

    inst_boot_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .prog_len          (prog_len),
        .src               (sif.slave),
        .inst_sram_wen     (wen),
        .inst_sram_waddr   (waddr),
        .inst_sram_wdata   (wdata),
        .inst_sram_en_toif (en_toif),
        .cpu_reset         (cpu_reset),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [63:0] a,
                             input logic [31:0] d);
        chk({tag, "_wen"}, {63'd0, wen}, 64'd1);
        chk({tag, "_waddr"}, waddr, a);
        chk({tag, "_wdata"}, {32'd0, wdata}, {32'd0, d});
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd0);
        chk({tag, "_en_toif"}, {63'd0, en_toif}, 64'd1);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    logic [31:0] prog [5];
    logic [31:0] stall_data [5];
    logic        stall_v [5];
    logic [63:0] stall_a [5];

    initial begin
        prog[0] = 32'h01400113; prog[1] = 32'h00100A13;
        prog[2] = 32'h00100A13; prog[3] = 32'h00100A13;
        prog[4] = 32'h00510193;
        stall_v[0] = 1; stall_v[1] = 0; stall_v[2] = 0;
        stall_v[3] = 1; stall_v[4] = 1;
        stall_a[0] = 1; stall_a[1] = 1; stall_a[2] = 1;
        stall_a[3] = 2; stall_a[4] = 3;
        for (int i = 0; i < 5; i++) stall_data[i] = 32'hA000_0000 + i;

        reset = 1; start = 0; prog_len = 0;
        sif.s_valid = 0; sif.s_data = 0;
        step();
        step();
        chk("rst_wen", {63'd0, wen}, 64'd0);
        chk("rst_waddr", waddr, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_en_toif", {63'd0, en_toif}, 64'd0);
        chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rst_s_ready", {63'd0, sif.s_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);

        // basic load of five words with ignored starts in LOAD and HOLD
        reset = 0;
        start = 1; prog_len = 5;
        step();
        start = 0;
        chk("ld_s_ready", {63'd0, sif.s_ready}, 64'd1);
        chk("ld_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            sif.s_valid = 1; sif.s_data = prog[i];
            start = (i == 2); prog_len = (i == 2) ? 16'd1 : 16'd5;
            step();
            chk_write($sformatf("ld_w%0d", i), 64'(i + 1), prog[i]);
        end
        start = 0;
        chk("ld_hold_ready", {63'd0, sif.s_ready}, 64'd0);
        chk("ld_hold_busy", {63'd0, busy}, 64'd1);
        chk("ld_hold_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        step();
        chk("ld_h1_wen", {63'd0, wen}, 64'd0);
        chk("ld_h1_waddr", waddr, 64'd5);
        chk("ld_h1_wdata", {32'd0, wdata}, {32'd0, prog[4]});
        sif.s_valid = 0;
        start = 1; prog_len = 1;
        step();
        start = 0;
        chk("ld_h2_wen", {63'd0, wen}, 64'd0);
        chk("ld_h2_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        step();
        chk("ld_h3_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("ld_h3_en_toif", {63'd0, en_toif}, 64'd0);
        step();
        chk_run("ld_run");

        // reload from RUN
        start = 1; prog_len = 2;
        step();
        start = 0;
        chk("rl_en_toif", {63'd0, en_toif}, 64'd0);
        chk("rl_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rl_s_ready", {63'd0, sif.s_ready}, 64'd1);
        sif.s_valid = 1; sif.s_data = 32'h1111_2222;
        step();
        chk_write("rl_w0", 64'd1, 32'h1111_2222);
        sif.s_data = 32'h3333_4444;
        step();
        chk_write("rl_w1", 64'd2, 32'h3333_4444);
        sif.s_valid = 0;
        repeat (3) step();
        chk("rl_pre_run", {63'd0, cpu_reset}, 64'd1);
        step();
        chk_run("rl_run");

        // stalled source
        start = 1; prog_len = 3;
        step();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            sif.s_valid = stall_v[i]; sif.s_data = stall_data[i];
            step();
            chk($sformatf("st_wen%0d", i), {63'd0, wen},
                {63'd0, stall_v[i]});
            chk($sformatf("st_waddr%0d", i), waddr, stall_a[i]);
        end
        chk("st_wdata_last", {32'd0, wdata}, {32'd0, stall_data[4]});
        chk("st_ready_off", {63'd0, sif.s_ready}, 64'd0);
        sif.s_valid = 0;
        repeat (4) step();
        chk_run("st_run");

        // illegal lengths
        start = 1; prog_len = 0;
        step();
        chk("il0_err", {63'd0, err}, 64'd1);
        chk("il0_ready", {63'd0, sif.s_ready}, 64'd0);
        chk("il0_done", {63'd0, done}, 64'd0);
        chk("il0_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        start = 0; sif.s_valid = 1;
        step();
        chk("il0_wen", {63'd0, wen}, 64'd0);
        chk("il0_ready2", {63'd0, sif.s_ready}, 64'd0);
        sif.s_valid = 0;
        start = 1; prog_len = 1025;
        step();
        chk("il1025_err", {63'd0, err}, 64'd1);
        prog_len = 1024;
        step();
        chk("il1024_load", {63'd0, sif.s_ready}, 64'd1);
        chk("il1024_err", {63'd0, err}, 64'd0);
        start = 0;
        reset = 1;
        step();
        reset = 0;
        start = 1; prog_len = 2;
        step();
        start = 0;
        chk("il2_ready", {63'd0, sif.s_ready}, 64'd1);
        chk("il2_busy", {63'd0, busy}, 64'd1);

        // reset after second handshake, with start and valid also high
        reset = 1;
        step();
        reset = 0;
        start = 1; prog_len = 4;
        step();
        start = 0;
        sif.s_valid = 1; sif.s_data = 32'hBEEF_0001;
        step();
        chk_write("rm_w0", 64'd1, 32'hBEEF_0001);
        sif.s_data = 32'hBEEF_0002;
        step();
        chk_write("rm_w1", 64'd2, 32'hBEEF_0002);
        reset = 1; start = 1; prog_len = 2; sif.s_data = 32'hBEEF_0003;
        step();
        reset = 0; start = 0;
        chk("rm_wen", {63'd0, wen}, 64'd0);
        chk("rm_waddr", waddr, 64'd0);
        chk("rm_wdata", {32'd0, wdata}, 64'd0);
        chk("rm_ready", {63'd0, sif.s_ready}, 64'd0);
        chk("rm_busy", {63'd0, busy}, 64'd0);
        chk("rm_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rm_en_toif", {63'd0, en_toif}, 64'd0);
        step();
        chk("rm_idle_wen", {63'd0, wen}, 64'd0);
        chk("rm_idle_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        sif.s_valid = 0;
        start = 1; prog_len = 2;
        step();
        start = 0;
        sif.s_valid = 1; sif.s_data = 32'hCAFE_0001;
        step();
        chk_write("rm2_w0", 64'd1, 32'hCAFE_0001);
        sif.s_data = 32'hCAFE_0002;
        step();
        chk_write("rm2_w1", 64'd2, 32'hCAFE_0002);
        sif.s_valid = 0;
        repeat (4) step();
        chk_run("rm2_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
